// File: rtl/consec_seq_checker.sv
// Multi-channel runtime monitor: after a trig rise, hold must be high for REPS
// consecutive cycles, then done must be high GAP cycles after the last hold sample.
module consec_seq_checker #(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned REPS     = 2,
    parameter int unsigned GAP      = 1,
    parameter int unsigned RESTART  = 0,
    parameter int unsigned COUNT_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trig,
    input  logic [CHANNELS-1:0] hold,
    input  logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] pass,
    output logic [CHANNELS-1:0] fail,
    output logic                any_fail,
    output logic [COUNT_W-1:0]  fail_count
);

    localparam int unsigned MAXRG = (REPS > GAP) ? REPS : GAP;
    localparam int unsigned CW    = $clog2(MAXRG + 1);
    localparam int unsigned SW    = COUNT_W + 6;

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_REP, S_GAP} state_e;

    localparam cnt_t          REPS_C = cnt_t'(REPS);
    localparam cnt_t          GAP_C  = cnt_t'(GAP);
    localparam logic [SW-1:0] SAT    = {{(SW-COUNT_W){1'b0}}, {COUNT_W{1'b1}}};

    state_e               state_q [CHANNELS];
    state_e               state_d [CHANNELS];
    cnt_t                 cnt_q   [CHANNELS];
    cnt_t                 cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]  trig_prev_q;
    logic [CHANNELS-1:0]  rise;
    logic [CHANNELS-1:0]  busy_q, busy_d;
    logic [CHANNELS-1:0]  pass_q, pass_d;
    logic [CHANNELS-1:0]  fail_q, fail_d;
    logic                 any_fail_q, any_fail_d;
    logic [COUNT_W-1:0]   fail_count_q, fail_count_d;
    logic [SW-1:0]        pop, sum;

    assign rise = trig & ~trig_prev_q;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pass_d[i]  = 1'b0;
            fail_d[i]  = 1'b0;
            unique case (state_q[i])
                S_IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = S_REP;
                        cnt_d[i]   = cnt_t'(1);
                    end
                end
                S_REP: begin
                    // A deciding sample always reports; a coincident rise still starts anew.
                    if (!hold[i]) begin
                        fail_d[i]  = 1'b1;
                        state_d[i] = rise[i] ? S_REP : S_IDLE;
                        cnt_d[i]   = cnt_t'(1);
                    end else if (rise[i] && (RESTART != 0)) begin
                        cnt_d[i]   = cnt_t'(1);
                    end else if (cnt_q[i] == REPS_C) begin
                        state_d[i] = S_GAP;
                        cnt_d[i]   = cnt_t'(1);
                    end else begin
                        cnt_d[i]   = cnt_q[i] + cnt_t'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q[i] == GAP_C) begin
                        pass_d[i]  = done[i];
                        fail_d[i]  = ~done[i];
                        state_d[i] = rise[i] ? S_REP : S_IDLE;
                        cnt_d[i]   = cnt_t'(1);
                    end else if (rise[i] && (RESTART != 0)) begin
                        state_d[i] = S_REP;
                        cnt_d[i]   = cnt_t'(1);
                    end else begin
                        cnt_d[i]   = cnt_q[i] + cnt_t'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            // busy covers the verdict cycle so the attempt window is contiguous
            busy_d[i] = (state_d[i] != S_IDLE) | pass_d[i] | fail_d[i];
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pop = pop + SW'(fail_d[i]);
        end
        sum          = SW'(fail_count_q) + pop;
        fail_count_d = (sum > SAT) ? SAT[COUNT_W-1:0] : sum[COUNT_W-1:0];
        any_fail_d   = any_fail_q | (|fail_d);
    end

    always_ff @(posedge clock) begin
        trig_prev_q <= trig;
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            busy_q       <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            any_fail_q   <= 1'b0;
            fail_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            any_fail_q   <= any_fail_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign busy       = busy_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign any_fail   = any_fail_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_consec_seq_checker.sv
// Three checker configurations share one stimulus stream; a start-time based
// reference model predicts every output each cycle.
module tb_consec_seq_checker;

    logic       clock;
    logic       reset;
    logic [3:0] trig, hold, done;

    logic [3:0] busy_w [3];
    logic [3:0] pass_w [3];
    logic [3:0] fail_w [3];
    logic       any_w  [3];
    logic [7:0] cnt_w  [3];
    logic [2:0] cnt_a, cnt_c;
    logic [7:0] cnt_b;

    assign cnt_w[0] = {5'b0, cnt_a};
    assign cnt_w[1] = cnt_b;
    assign cnt_w[2] = {5'b0, cnt_c};

    consec_seq_checker #(.CHANNELS(4), .REPS(3), .GAP(2), .RESTART(1), .COUNT_W(3)) dut_a (
        .clock(clock), .reset(reset), .trig(trig), .hold(hold), .done(done),
        .busy(busy_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
        .any_fail(any_w[0]), .fail_count(cnt_a));

    consec_seq_checker #(.CHANNELS(4), .REPS(2), .GAP(1), .RESTART(0), .COUNT_W(8)) dut_b (
        .clock(clock), .reset(reset), .trig(trig), .hold(hold), .done(done),
        .busy(busy_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
        .any_fail(any_w[1]), .fail_count(cnt_b));

    consec_seq_checker #(.CHANNELS(4), .REPS(3), .GAP(2), .RESTART(0), .COUNT_W(3)) dut_c (
        .clock(clock), .reset(reset), .trig(trig), .hold(hold), .done(done),
        .busy(busy_w[2]), .pass(pass_w[2]), .fail(fail_w[2]),
        .any_fail(any_w[2]), .fail_count(cnt_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    int reps_c [3] = '{3, 2, 3};
    int gap_c  [3] = '{2, 1, 2};
    int rst_c  [3] = '{1, 0, 0};
    int cmax_c [3] = '{7, 255, 7};

    // Model state: cycle at which the live attempt's rise was sampled, -1 if none.
    int         start_m [3][4];
    logic [3:0] prev_trig_m;
    logic [3:0] e_busy [3];
    logic [3:0] e_pass [3];
    logic [3:0] e_fail [3];
    logic       e_any  [3];
    int         e_cnt  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                for (int c = 0; c < 4; c++) start_m[m][c] = -1;
                e_busy[m] = '0; e_pass[m] = '0; e_fail[m] = '0;
                e_any[m]  = 1'b0; e_cnt[m] = 0;
            end else begin
                int nf;
                nf = 0;
                for (int c = 0; c < 4; c++) begin
                    bit r, p, f, decided;
                    int k;
                    r = trig[c] && !prev_trig_m[c];
                    p = 0; f = 0; decided = 0;
                    if (start_m[m][c] >= 0) begin
                        k = n - start_m[m][c];
                        if (k <= reps_c[m]) begin
                            if (!hold[c]) begin f = 1; decided = 1; end
                        end else if (k == reps_c[m] + gap_c[m]) begin
                            p = done[c]; f = !done[c]; decided = 1;
                        end
                    end
                    if (r && (start_m[m][c] < 0 || decided || rst_c[m] != 0))
                        start_m[m][c] = n;
                    else if (decided)
                        start_m[m][c] = -1;
                    e_pass[m][c] = p;
                    e_fail[m][c] = f;
                    e_busy[m][c] = (start_m[m][c] >= 0) || p || f;
                    nf += int'(f);
                end
                e_cnt[m] = (e_cnt[m] + nf > cmax_c[m]) ? cmax_c[m] : e_cnt[m] + nf;
                e_any[m] = e_any[m] || (nf > 0);
            end
        end
        prev_trig_m = trig;
    endtask

    task automatic cyc(input logic [3:0] t, input logic [3:0] h, input logic [3:0] d, input logic r);
        trig = t; hold = h; done = d; reset = r;
        @(posedge clock);
        model_step();
        #1;
        n++;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("inst%0d busy", m), 32'(busy_w[m]), 32'(e_busy[m]));
            chk($sformatf("inst%0d pass", m), 32'(pass_w[m]), 32'(e_pass[m]));
            chk($sformatf("inst%0d fail", m), 32'(fail_w[m]), 32'(e_fail[m]));
            chk($sformatf("inst%0d any_fail", m), 32'(any_w[m]), 32'(e_any[m]));
            chk($sformatf("inst%0d fail_count", m), 32'(cnt_w[m]), 32'(e_cnt[m]));
        end
    endtask

    initial begin
        trig = '0; hold = '0; done = '0; reset = 1'b1;
        prev_trig_m = '0;
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < 4; c++) start_m[m][c] = -1;
        end
        #2;

        // B: full pass, verdict one cycle after done is sampled
        cyc(4'h0, 4'h0, 4'h0, 1'b1);
        chk("reset busy_b", 32'(busy_w[1]), 32'h0);
        chk("reset count_b", 32'(cnt_w[1]), 32'h0);
        cyc(4'h1, 4'h0, 4'h0, 1'b0);
        cyc(4'h1, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 4'h1, 1'b0);
        chk("dir pass_b0", 32'(pass_w[1][0]), 32'h1);
        chk("dir busy_b0 verdict", 32'(busy_w[1][0]), 32'h1);
        chk("dir count_b no fail", 32'(cnt_w[1]), 32'h0);
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("dir busy_b0 after", 32'(busy_w[1][0]), 32'h0);

        // B: hold low on first sample
        cyc(4'h1, 4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("dir fail_b0", 32'(fail_w[1][0]), 32'h1);
        chk("dir any_b", 32'(any_w[1]), 32'h1);
        chk("dir count_b one", 32'(cnt_w[1]), 32'h1);

        // reset mid-attempt, then trig held across release
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        cyc(4'h1, 4'h0, 4'h0, 1'b0);
        cyc(4'h1, 4'h1, 4'h0, 1'b0);
        cyc(4'h1, 4'h0, 4'h0, 1'b1);
        chk("dir abort busy_b0", 32'(busy_w[1][0]), 32'h0);
        chk("dir abort fail_b0", 32'(fail_w[1][0]), 32'h0);
        cyc(4'h1, 4'h1, 4'h1, 1'b0);
        cyc(4'h1, 4'h1, 4'h1, 1'b0);
        chk("dir held trig busy_b0", 32'(busy_w[1][0]), 32'h0);
        chk("dir held trig busy_a0", 32'(busy_w[0][0]), 32'h0);

        // REPS=3 GAP=2: restart (A) vs ignore (C) on a second rise
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        cyc(4'h1, 4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h1, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h1, 1'b0);
        chk("dir pass_c0 ignore", 32'(pass_w[2][0]), 32'h1);
        chk("dir pass_a0 early", 32'(pass_w[0][0] | fail_w[0][0]), 32'h0);
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("dir busy_a0 restarted", 32'(busy_w[0][0]), 32'h1);
        cyc(4'h0, 4'h0, 4'h1, 1'b0);
        chk("dir pass_a0 restart", 32'(pass_w[0][0]), 32'h1);

        // all four channels fail together, twice
        cyc(4'h0, 4'h0, 4'h0, 1'b1);
        cyc(4'hF, 4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("dir count_a four", 32'(cnt_w[0]), 32'd4);
        chk("dir fail_a all", 32'(fail_w[0]), 32'hF);
        cyc(4'hF, 4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b0);
        chk("dir count_a sat", 32'(cnt_w[0]), 32'd7);
        chk("dir count_c sat", 32'(cnt_w[2]), 32'd7);
        chk("dir count_b eight", 32'(cnt_w[1]), 32'd8);

        // B: rise coincides with a done-low deciding sample
        cyc(4'h1, 4'h0, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h1, 4'h0, 4'h0, 1'b0);
        chk("dir coincide fail_b0", 32'(fail_w[1][0]), 32'h1);
        chk("dir coincide busy_b0", 32'(busy_w[1][0]), 32'h1);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h1, 4'h0, 1'b0);
        cyc(4'h0, 4'h0, 4'h1, 1'b0);
        chk("dir coincide pass_b0", 32'(pass_w[1][0]), 32'h1);

        // randomized traffic
        for (int r = 0; r < 3000; r++) begin
            logic [3:0] t, h, d;
            logic       rs;
            t  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            h  = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 99) == 0);
            cyc(t, h, d, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/consec_seq_checker.md
Name: consec_seq_checker

Overview:
Synthesizable, multi-channel runtime checker for the property "after trig rises, hold is high for REPS consecutive cycles, then GAP cycles later done is high". It generalises the fixed b[*2] ##1 c check to parametrised repetition count, gap length, channel count and re-trigger mode. Each channel reports pass/fail pulses. Shared outputs give a sticky error flag and a saturating failure counter. It sits beside the design under test in demo and bring-up builds as a hardware monitor.

Parameters:
CHANNELS, 1, number of independent checker channels (1..32)
REPS, 2, consecutive cycles hold must be high after the rise (>=1)
GAP, 1, cycles from the last hold sample to the done sample (>=1)
RESTART, 0, 1: a new rise while busy restarts the attempt; 0: the rise is ignored while busy
COUNT_W, 8, width of fail_count

Ports:
clock  input  1  sole clock; all logic on posedge
reset  input  1  synchronous, active-high; disables all checking
trig  input  CHANNELS  per-channel trigger; rising edge starts an attempt
hold  input  CHANNELS  per-channel signal that must stay high for REPS cycles
done  input  CHANNELS  per-channel completion signal sampled once
busy  output  CHANNELS  channel has an attempt in flight
pass  output  CHANNELS  one-cycle pulse: attempt succeeded
fail  output  CHANNELS  one-cycle pulse: attempt failed
any_fail  output  1  sticky OR of all fail pulses since reset
fail_count  output  COUNT_W  saturating total of fail pulses since reset

Behaviour:
- Reset (sync): all channels go to IDLE; busy, pass, fail, any_fail and fail_count are 0 at the edge after reset is sampled high. trig_prev loads trig every cycle, including during reset, so a trig held high across reset release is not a rise.
- rise[i] = trig[i] & ~trig_prev[i]. This is evaluated on every non-reset cycle.
- Per-channel FSM: IDLE -> REP -> GAP -> IDLE. The counter width is clog2(max(REPS,GAP)+1).
- IDLE: if rise is sampled at cycle t, go to REP with cnt=1 and busy=1 from t+1.
- REP: sample hold at cycles t+1..t+REPS.
  - hold low at cycle t+k: fail pulses at t+k+1 and the channel goes to IDLE.
  - After the REPS-th high sample, go to GAP with cnt=1.
- GAP: cycles t+REPS+1..t+REPS+GAP-1 are don't-care. done is sampled at cycle t+REPS+GAP.
  - done high: pass at the next cycle.
  - done low: fail at the next cycle.
  - Either way the channel goes to IDLE.
- Latency: verdict pulses are registered, one cycle after the deciding sample. A full pass pulses at t+REPS+GAP+1.
- Completion vs. new rise: when a rise is sampled on the same cycle as the deciding sample, the verdict is still reported. The new attempt starts in both RESTART modes, and busy stays 1.
- Rise while busy and not deciding:
  - RESTART=1: the attempt restarts from REP cnt=1 with no verdict for the old attempt.
  - RESTART=0: the rise is ignored.
- Reset mid-attempt: the attempt is aborted silently, with no fail pulse and no count.
- pass and fail are never both high on one channel in the same cycle.
- any_fail: set by any fail bit and cleared only by reset.
- fail_count: adds popcount(fail) each cycle and saturates at 2^COUNT_W-1 with no wrap. Several channels failing in the same cycle add their combined count.
- Channels are fully independent and share only any_fail and fail_count.

Test Plan:
- Ch0, REPS=2, GAP=1: reset at cycle 0; trig high 1-2; hold high 2-3; done high at 4 -> pass[0]=1 at cycle 5 only, fail_count=0, busy[0]=1 for cycles 2-5.
- Same config: trig rises at 14; hold low at 15, high 16-17 -> fail[0]=1 at cycle 16, any_fail=1 from 16 onward, fail_count=1.
- Trig rises at 6, hold high at 7, reset high at 8 -> no pass or fail, busy=0 at 9, counters unchanged. Then trig held high across reset release -> no attempt starts.
- REPS=3, GAP=2, RESTART=1: rise at 10, hold high from 11, second rise at 12 -> verdict at 12+3+2+1=18 only, nothing at 16. With RESTART=0 the verdict is at 16.
- CHANNELS=4, COUNT_W=3: all four channels fail on the same cycle, twice -> fail_count goes 0 -> 4 -> 7 (saturated). any_fail=1.
- Rise coincides with a done-low deciding sample at cycle 20 -> fail at 21, busy stays 1, the new attempt's verdict arrives at 20+REPS+GAP+1.
